// File: rtl/accum_bank_pp.sv
// Ping-pong accumulator memory between the systolic array output and the VPU drain path.
// The write side does overwrite/accumulate into the active bank; the read side drains the other bank.
module accum_bank_pp #(
    parameter int NUM_COLS = 2,
    parameter int COL_W    = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    output logic                      wr_ready,
    input  logic                      wr_accum,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [NUM_COLS*COL_W-1:0] wr_data,
    input  logic                      rd_en,
    output logic                      rd_ready,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [NUM_COLS*COL_W-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      buf_swap,
    output logic                      active_bank,
    input  logic                      clear,
    input  logic                      clear_sel,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      ovf_flag,
    output logic [1:0]                clear_state
);

    localparam int W = NUM_COLS * COL_W;
    localparam logic [COL_W-1:0] SAT_MAX = {1'b0, {(COL_W-1){1'b1}}};
    localparam logic [COL_W-1:0] SAT_MIN = {1'b1, {(COL_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Handshake: a write transfers on a rising clk edge where wr_en && wr_ready; a read
    // transfers where rd_en && rd_ready, and its data appears with rd_valid one cycle later.

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    clr_state_t         state;
    logic [ADDR_W-1:0]  clr_addr;
    logic               clr_bank;
    logic               swap_pending;

    logic               s1_valid;
    logic               s1_accum;
    logic               s1_bank;
    logic [ADDR_W-1:0]  s1_addr;
    logic [W-1:0]       s1_data;
    logic [W-1:0]       s1_old;
    logic [W-1:0]       s1_result;
    logic               s1_ovf;

    logic [W-1:0]       mem [2][DEPTH];

    logic               clear_start;
    logic               clr_on_active;
    logic               clr_on_inactive;
    logic               wr_fire;
    logic               rd_fire;
    logic               swap_commit;
    logic               clr_stall;
    logic               clr_write;
    logic               fwd_hit;

    logic [COL_W-1:0]   lane_a;
    logic [COL_W-1:0]   lane_b;
    logic [COL_W:0]     lane_sum;

    logic               bank_we    [2];
    logic [ADDR_W-1:0]  bank_waddr [2];
    logic [W-1:0]       bank_wdata [2];

    assign clear_start     = (state == CLR_IDLE) && clear;
    assign clr_on_active   = ((state == CLR_RUN) && (clr_bank == active_bank)) ||
                             (clear_start && (clear_sel == active_bank));
    assign clr_on_inactive = ((state == CLR_RUN) && (clr_bank != active_bank)) ||
                             (clear_start && (clear_sel != active_bank));

    assign wr_ready   = !swap_pending && !clr_on_active;
    assign rd_ready   = !clr_on_inactive;
    assign wr_fire    = wr_en && wr_ready;
    assign rd_fire    = rd_en && rd_ready;
    assign clear_busy = (state == CLR_RUN) || clear_start;
    assign clear_done = (state == CLR_DONE);
    assign clear_state = state;

    // A pending swap yields to a clear requested in the same cycle.
    assign swap_commit = swap_pending && !s1_valid && !wr_fire && (state == CLR_IDLE) && !clear;

    // Keeps the zero sweep from colliding with a write still draining out of S1.
    assign clr_stall = s1_valid && (s1_bank == clr_bank);
    assign clr_write = (state == CLR_RUN) && !clr_stall;

    assign fwd_hit = s1_valid && (s1_bank == active_bank) && (s1_addr == wr_addr);

    always_comb begin
        s1_result = s1_data;
        s1_ovf    = 1'b0;
        lane_a    = '0;
        lane_b    = '0;
        lane_sum  = '0;
        if (s1_accum) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                lane_a   = s1_old[c*COL_W +: COL_W];
                lane_b   = s1_data[c*COL_W +: COL_W];
                lane_sum = {lane_a[COL_W-1], lane_a} + {lane_b[COL_W-1], lane_b};
                s1_result[c*COL_W +: COL_W] = lane_sum[COL_W-1:0];
                // The two top bits of the sign-extended sum disagree exactly on overflow.
                if (lane_sum[COL_W] != lane_sum[COL_W-1]) begin
                    s1_ovf = 1'b1;
                    if (SATURATE != 0) begin
                        s1_result[c*COL_W +: COL_W] = lane_sum[COL_W] ? SAT_MIN : SAT_MAX;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = (s1_valid && (s1_bank == 1'(b))) || (clr_write && (clr_bank == 1'(b)));
            bank_waddr[b] = (clr_write && (clr_bank == 1'(b))) ? clr_addr : s1_addr;
            bank_wdata[b] = (clr_write && (clr_bank == 1'(b))) ? '0 : s1_result;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bank_we[b]) begin
                mem[b][bank_waddr[b]] <= bank_wdata[b];
            end
        end
    end

    // S0: operand fetch, with the in-flight S1 result taking priority over stale memory.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            s1_addr  <= wr_addr;
            s1_data  <= wr_data;
            s1_accum <= wr_accum;
            s1_bank  <= active_bank;
            s1_old   <= fwd_hit ? s1_result : mem[active_bank][wr_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLR_IDLE;
            clr_addr     <= '0;
            clr_bank     <= 1'b0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
            ovf_flag     <= 1'b0;
            s1_valid     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            s1_valid <= wr_fire;
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[~active_bank][rd_addr];
            end

            case (state)
                CLR_IDLE: begin
                    if (clear) begin
                        state    <= CLR_RUN;
                        clr_addr <= '0;
                        clr_bank <= clear_sel;
                    end
                end
                CLR_RUN: begin
                    if (!clr_stall) begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == LAST_ADDR) begin
                            state <= CLR_DONE;
                        end
                    end
                end
                CLR_DONE: state <= CLR_IDLE;
                default:  state <= CLR_IDLE;
            endcase

            if (swap_commit) begin
                active_bank  <= ~active_bank;
                swap_pending <= 1'b0;
            end else if (buf_swap) begin
                swap_pending <= 1'b1;
            end

            if (swap_commit || (clear_start && (clear_sel == active_bank))) begin
                ovf_flag <= 1'b0;
            end else if (s1_valid && s1_ovf) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule
